// File: rtl/dac_pkg.sv
// dac_pkg: shared code width, mode encodings and FSM states for the DAC sample sequencer
package dac_pkg;

   localparam int DAC_CODE_W = 12;

   typedef enum logic [1:0] {
      MODE_CONST = 2'b00,
      MODE_SAW   = 2'b01,
      MODE_TRI   = 2'b10,
      MODE_RSVD  = 2'b11
   } dac_mode_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_TICK,
      PRESENT
   } dac_state_e;

endpackage

// File: rtl/dac_rate_tick.sv
// dac_rate_tick: sample-period counter, one-cycle tick every rate_div+1 cycles while not cleared
module dac_rate_tick #(
   parameter int RATE_W = 16
) (
   input  logic              clk_X4,
   input  logic              rst_n,
   input  logic              clear,
   input  logic [RATE_W-1:0] rate_div,
   output logic              tick
);

   logic [RATE_W-1:0] cnt_q, cnt_d;

   // tick on terminal count, then restart from zero; clear holds the count at zero
   always_comb begin
      tick  = !clear && (cnt_q == rate_div);
      cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
   end

   // counter register, shares the DAC driver's falling edge
   always_ff @(negedge clk_X4 or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;

endmodule

// File: rtl/dac_sample_sequencer.sv
// dac_sample_sequencer: paced constant/sawtooth/triangle code generator with valid/ready output
// Triangle mode is built only when DAC_SEQ_TRIANGLE_EN is defined; otherwise mode 10 acts as sawtooth.
module dac_sample_sequencer
   import dac_pkg::*;
#(
   parameter int DATA_W = DAC_CODE_W,
   parameter int RATE_W = 16
) (
   input  logic              clk_X4,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] const_code,
   input  logic [DATA_W-1:0] step,
   input  logic [RATE_W-1:0] rate_div,
   output logic [DATA_W-1:0] sample,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              overrun
);

   dac_state_e        state_q, state_d;
   logic [DATA_W-1:0] sample_q, sample_d, adv;
   logic              valid_q, valid_d, overrun_q, overrun_d;
   logic              tick, xfer, clear;
`ifdef DAC_SEQ_TRIANGLE_EN
   logic [DATA_W:0]   sum;
   logic              dn_q, dn_d, adv_dn;
`endif

   assign xfer         = valid_q && sample_ready;
   assign clear        = (state_q == IDLE);
   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign overrun      = overrun_q;

   dac_rate_tick #(.RATE_W(RATE_W)) u_rate_tick (
      .clk_X4   (clk_X4),
      .rst_n    (rst_n),
      .clear    (clear),
      .rate_div (rate_div),
      .tick     (tick)
   );

   // code that follows the current one once it has been accepted
   always_comb begin
      adv = (mode == MODE_SAW || mode == MODE_TRI) ? sample_q + step : const_code;
`ifdef DAC_SEQ_TRIANGLE_EN
      sum    = {1'b0, sample_q} + {1'b0, step};
      adv_dn = dn_q;
      if (mode == MODE_TRI && !dn_q) begin
         adv    = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
         adv_dn = sum[DATA_W];
      end else if (mode == MODE_TRI) begin
         adv    = (sample_q < step) ? '0 : sample_q - step;
         adv_dn = !(sample_q < step);
      end
`endif
   end

   // sequencing: load on start, advance on transfer, flag ticks that find the sample still pending
   always_comb begin
      state_d   = state_q;
      sample_d  = sample_q;
      overrun_d = overrun_q;
`ifdef DAC_SEQ_TRIANGLE_EN
      dn_d      = dn_q;
`endif
      if (!enable) begin
         state_d   = IDLE;
         overrun_d = 1'b0;
      end else if (state_q == IDLE) begin
         state_d  = WAIT_TICK;
         sample_d = const_code;
`ifdef DAC_SEQ_TRIANGLE_EN
         dn_d     = 1'b0;
`endif
      end else begin
         if (xfer) begin
            sample_d = adv;
`ifdef DAC_SEQ_TRIANGLE_EN
            dn_d     = adv_dn;
`endif
         end
         if (tick && valid_q && !xfer) overrun_d = 1'b1;
         state_d = (tick || (valid_q && !xfer)) ? PRESENT : WAIT_TICK;
      end
      valid_d = (state_d == PRESENT);
   end

   // state and registered outputs
   always_ff @(negedge clk_X4 or negedge rst_n)
      if (!rst_n) begin
         state_q   <= IDLE;
         sample_q  <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
`ifdef DAC_SEQ_TRIANGLE_EN
         dn_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
`ifdef DAC_SEQ_TRIANGLE_EN
         dn_q      <= dn_d;
`endif
      end

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// tb_dac_sample_sequencer: randomized and directed checks of the sequencer against a behavioural model
module tb_dac_sample_sequencer;

`ifdef DAC_SEQ_TRIANGLE_EN
   localparam bit TRI = 1'b1;
`else
   localparam bit TRI = 1'b0;
`endif

   logic        clk_X4 = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [11:0] const_code = '0;
   logic [11:0] step = '0;
   logic [15:0] rate_div = '0;
   logic        sample_ready = 1'b0;
   logic [11:0] sample;
   logic        sample_valid;
   logic        overrun;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;
   int cyc = 0;
   int xq[$];
   int xt[$];

   int m_active = 0, m_valid = 0, m_code = 0, m_dn = 0, m_ovr = 0, m_cnt = 0;

   dac_sample_sequencer dut (
      .clk_X4       (clk_X4),
      .rst_n        (rst_n),
      .enable       (enable),
      .mode         (mode),
      .const_code   (const_code),
      .step         (step),
      .rate_div     (rate_div),
      .sample       (sample),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun)
   );

   always #5 clk_X4 = ~clk_X4;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // code after an accepted sample, straight from the mode rules
   task automatic model_adv();
      int s;
      if (TRI && mode == 2'd2) begin
         if (m_dn == 0) begin
            s = m_code + int'(step);
            if (s > 4095) begin m_code = 4095; m_dn = 1; end
            else m_code = s;
         end else if (m_code < int'(step)) begin
            m_code = 0; m_dn = 0;
         end else m_code = m_code - int'(step);
      end else if (mode == 2'd1 || mode == 2'd2) m_code = (m_code + int'(step)) % 4096;
      else m_code = int'(const_code);
   endtask

   task automatic model_step();
      bit xfer, tk;
      xfer = (m_valid != 0) && sample_ready;
      if (!enable) begin
         m_active = 0; m_valid = 0; m_ovr = 0;
      end else if (m_active == 0) begin
         m_active = 1; m_code = int'(const_code); m_dn = 0; m_cnt = 0;
      end else begin
         tk = (m_cnt == int'(rate_div));
         m_cnt = tk ? 0 : m_cnt + 1;
         if (xfer) model_adv();
         if (m_valid != 0 && !xfer && tk) m_ovr = 1;
         m_valid = (m_valid != 0 && !xfer) ? 1 : int'(tk);
      end
   endtask

   always @(negedge clk_X4 or negedge rst_n)
      if (!rst_n) begin
         m_active = 0; m_valid = 0; m_code = 0; m_dn = 0; m_ovr = 0; m_cnt = 0;
      end else model_step();

   // per-cycle compare, also logs accepted samples and their cycle numbers
   always @(posedge clk_X4) begin
      #3;
      cyc++;
      if (chk_en) begin
         check("valid", int'(sample_valid), m_valid);
         check("overrun", int'(overrun), m_ovr);
         if (m_valid != 0 || !rst_n) check("sample", int'(sample), m_code);
      end
      if (sample_valid && sample_ready && rst_n) begin
         xq.push_back(int'(sample));
         xt.push_back(cyc);
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk_X4); #1; end
   endtask

   task automatic restart(input logic [1:0] md, input int cc, input int st, input int rd, input logic rdy);
      enable = 1'b0;
      cycles(2);
      mode = md; const_code = 12'(cc); step = 12'(st); rate_div = 16'(rd); sample_ready = rdy;
      xq.delete(); xt.delete();
      enable = 1'b1;
   endtask

   task automatic wait_xfers(input int n, input string name);
      int k = 0;
      while (xq.size() < n && k < 500) begin cycles(1); k++; end
      check({name, "_count"}, int'(xq.size() >= n), 1);
   endtask

   initial begin
      int exp_q[$];
      cycles(3);
      chk_en = 1'b1;
      check("rst_valid", int'(sample_valid), 0);
      check("rst_sample", int'(sample), 0);
      check("rst_overrun", int'(overrun), 0);
      rst_n = 1'b1;
      cycles(2);

      restart(2'd0, 'h800, 0, 3, 1'b1);
      cycles(30);
      check("const_count", int'(xq.size() >= 5), 1);
      for (int i = 0; i < 4; i++) begin
         check("const_code", xq[i], 'h800);
         check("const_period", xt[i+1] - xt[i], 4);
      end
      check("const_overrun", int'(overrun), 0);

      restart(2'd1, 'hFF0, 'h010, 2, 1'b1);
      wait_xfers(3, "saw");
      exp_q = '{'hFF0, 'h000, 'h010};
      foreach (exp_q[i]) check("saw_wrap", xq[i], exp_q[i]);

`ifdef DAC_SEQ_TRIANGLE_EN
      restart(2'd2, 'hFF0, 'h020, 3, 1'b1);
      wait_xfers(2, "tri");
      step = 12'hFCF;
      wait_xfers(3, "tri");
      step = 12'h020;
      wait_xfers(6, "tri");
      exp_q = '{'hFF0, 'hFFF, 'hFDF, 'h010, 'h000, 'h020};
      foreach (exp_q[i]) check("tri_fold", xq[i], exp_q[i]);
`else
      restart(2'd2, 'hFF0, 'h020, 2, 1'b1);
      wait_xfers(2, "tri_off");
      exp_q = '{'hFF0, 'h010};
      foreach (exp_q[i]) check("tri_off_saw", xq[i], exp_q[i]);
`endif

      restart(2'd1, 'h100, 1, 1, 1'b0);
      cycles(7);
      check("bp_overrun", int'(overrun), 1);
      check("bp_valid", int'(sample_valid), 1);
      check("bp_sample", int'(sample), 'h100);
      sample_ready = 1'b1;
      wait_xfers(1, "bp");
      check("bp_xfer", xq[0], 'h100);
      cycles(4);
      check("bp_sticky", int'(overrun), 1);
      enable = 1'b0;
      cycles(2);
      check("bp_clear", int'(overrun), 0);

      restart(2'd0, 'h555, 0, 2, 1'b0);
      cycles(6);
      check("rp_valid", int'(sample_valid), 1);
      rst_n = 1'b0;
      #1;
      check("rp_rst_valid", int'(sample_valid), 0);
      check("rp_rst_sample", int'(sample), 0);
      cycles(1);
      const_code = 12'h3A0;
      sample_ready = 1'b1;
      xq.delete(); xt.delete();
      rst_n = 1'b1;
      wait_xfers(1, "rp");
      check("rp_first", xq[0], 'h3A0);

      for (int r = 0; r < 30; r++) begin
         int sel;
         sel = int'($urandom_range(0, 3));
         restart(2'($urandom_range(0, 3)), int'($urandom_range(0, 4095)),
                 sel == 0 ? 0 : sel == 1 ? int'($urandom_range(1, 64)) : int'($urandom_range(0, 4095)),
                 int'($urandom_range(0, 4)), 1'b1);
         for (int c = 0; c < 80; c++) begin
            sample_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) step = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 19) == 0) const_code = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 99) == 0) enable = 1'b0;
            else enable = 1'b1;
            if ($urandom_range(0, 149) == 0) begin
               rst_n = 1'b0;
               cycles(1);
               rst_n = 1'b1;
            end
            cycles(1);
         end
      end

      enable = 1'b0;
      cycles(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/dac_sample_sequencer.md
DAC_SAMPLE_SEQUENCER -- requirements
Module: dac_sample_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 12, DAC code width.
REQ-002 SHALL have parameter RATE_W, default 16, sample-period divider width.
REQ-003 SHALL have port clk_X4  input  1  system clock (same clock as the DAC serial driver); one clock, all logic on its negedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  high enable; low forces IDLE.
REQ-006 SHALL have port mode  input  2  00 constant, 01 sawtooth, 10 triangle, 11 reserved (treated as constant).
REQ-007 SHALL have port const_code  input  DATA_W  code emitted in constant mode and start code for ramps.
REQ-008 SHALL have port step  input  DATA_W  ramp increment per sample.
REQ-009 SHALL have port rate_div  input  RATE_W  sample period in clk_X4 cycles minus 1.
REQ-010 SHALL have port sample  output  DATA_W  code offered downstream.
REQ-011 SHALL have port sample_valid  output  1  sample offered.
REQ-012 SHALL have port sample_ready  input  1  downstream DAC driver accepts sample.
REQ-013 SHALL have port overrun  output  1  sticky: sample tick arrived while previous sample not accepted.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT_TICK, PRESENT.
REQ-015 IDLE -> WAIT_TICK when enable=1; any state -> IDLE on the cycle after enable=0.
REQ-016 On IDLE exit, code register SHALL load const_code, direction SHALL be up, period counter SHALL clear.
REQ-017 Period counter SHALL increment each cycle outside IDLE; tick when counter==rate_div, counter then reloads 0; rate_div=0 gives a tick every cycle.
REQ-018 WAIT_TICK -> PRESENT on tick; sample_valid SHALL assert the cycle after the tick, sample stable while valid.
REQ-019 Transfer SHALL occur on a cycle with sample_valid=1 and sample_ready=1; PRESENT -> WAIT_TICK next cycle, code register advances.
REQ-020 Tick in PRESENT without transfer on that cycle SHALL set overrun, be dropped, and leave sample unchanged.
REQ-021 Simultaneous tick and transfer SHALL count as transfer; no overrun; next state PRESENT with the advanced code.
REQ-022 Sawtooth: next = (code + step) mod 2^DATA_W (wrap-around).
REQ-023 Triangle up: if code+step > 2^DATA_W-1, next = 2^DATA_W-1 and direction down; else code+step.
REQ-024 Triangle down: if code < step, next = 0 and direction up; else code-step.
REQ-025 Constant/reserved: next = const_code sampled at transfer.
REQ-026 step=0 SHALL hold the code in all modes with no direction change.
REQ-027 mode change mid-run SHALL take effect at the next transfer; direction preserved.
REQ-028 overrun SHALL clear only in IDLE or reset.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, sample=0, sample_valid=0, overrun=0, counter=0, direction up.
REQ-030 Reset mid-PRESENT SHALL drop the pending sample without a transfer.

Configuration
REQ-031 Macro DAC_SEQ_TRIANGLE_EN defined: triangle mode per REQ-023/024.
REQ-032 Macro DAC_SEQ_TRIANGLE_EN undefined: direction register and triangle logic absent; mode 10 SHALL behave as sawtooth.

Structure
REQ-033 Shared package dac_pkg SHALL hold DAC_CODE_W=12, mode encodings, FSM state enum.
REQ-034 Period counter SHALL be sub-module dac_rate_tick (inputs clk_X4, rst_n, clear, rate_div; output tick).

Verification
REQ-035 Constant: mode=00, const_code=0x800, rate_div=3, ready=1 -> valid every 4 cycles, sample=0x800, overrun=0.
REQ-036 Sawtooth wrap: const_code=0xFF0, step=0x010 -> samples 0xFF0, 0x000, 0x010.
REQ-037 Triangle (macro on): const_code=0xFF0, step=0x020 -> 0xFF0, 0xFFF, 0xFDF; then from 0x010 with step 0x020 down -> 0x000, 0x020.
REQ-038 Backpressure: rate_div=1, ready=0 for 6 cycles -> overrun=1, sample unchanged; ready=1 -> transfer, overrun stays 1 until enable=0.
REQ-039 Reset mid-PRESENT: rst_n low while valid=1 -> valid=0, sample=0 same cycle; after release with enable=1 first sample = const_code.
REQ-040 Macro off: mode=10, const_code=0xFF0, step=0x020 -> 0xFF0, 0x010.
